// File: rtl/euler_pkg.sv
// Shared definitions for the Euler step controller: FSM state encoding and
// watchdog timing constants.
package euler_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_WAIT_ROW = 3'd2,
    S_ACK_ROW  = 3'd3,
    S_END_PASS = 3'd4,
    S_DONE     = 3'd5,
    S_ERROR    = 3'd6
  } state_e;

  // Watchdog limit for one row wait is WD_MULT * columns + WD_OFFSET cycles.
  localparam int unsigned WD_MULT   = 4;
  localparam int unsigned WD_OFFSET = 16;

endpackage

// File: rtl/euler_watchdog.sv
// Saturating cycle counter that flags when a row wait has used up its budget.
module euler_watchdog #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count up while enabled and stop at all-ones.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // The current enabled cycle is the limit-th one since the last clear.
  assign expired = enable && (count_q >= (limit - W'(1)));

endmodule

// File: rtl/euler_step_controller.sv
// Sequences Euler integration steps over a matrix pipeline: one launch per
// step, one acknowledge per row, an end-of-pass pulse per step, with an
// overflow/watchdog abort path into a sticky error.
module euler_step_controller
  import euler_pkg::*;
#(
  parameter int ADD_SIZE  = 16,
  parameter int DATA_SIZE = 16,
  parameter int MAX_DIM   = 6,
  parameter int STEP_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [STEP_W-1:0]   num_steps,
  input  logic [MAX_DIM-1:0]  shape_0,
  input  logic [MAX_DIM-1:0]  shape_1,
  input  logic                pipe_data_ready,
  input  logic [ADD_SIZE-1:0] pipe_out_acc,
  input  logic                pipe_overflow,
  output logic                pipe_start,
  output logic                pipe_return_default,
  output logic                pipe_final_done,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                result_valid,
  output logic [MAX_DIM-1:0]  result_row,
  output logic [ADD_SIZE-1:0] result_data,
  output logic [STEP_W-1:0]   step_count
);

  // Wide enough for WD_MULT * (2**MAX_DIM - 1) + WD_OFFSET.
  localparam int WD_W = MAX_DIM + 3;

  state_e              state_q, state_d;
  logic [MAX_DIM-1:0]  shape0_q, shape0_d;
  logic [MAX_DIM-1:0]  shape1_q, shape1_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [MAX_DIM-1:0]  row_q, row_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                error_q, error_d;
  logic                res_valid_q, res_valid_d;
  logic [MAX_DIM-1:0]  res_row_q, res_row_d;
  logic [ADD_SIZE-1:0] res_data_q, res_data_d;

  logic                wd_clear, wd_enable, wd_expired;
  logic [WD_W-1:0]     wd_limit;
  logic                ovf_abort;

  assign wd_limit = WD_W'(shape1_q) * WD_W'(WD_MULT) + WD_W'(WD_OFFSET);

  euler_watchdog #(.W(WD_W)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .limit   (wd_limit),
    .expired (wd_expired)
  );

  // Overflow aborts from any working state; DONE and ERROR are already finishing.
  assign ovf_abort = pipe_overflow &&
                     ((state_q == S_LAUNCH) || (state_q == S_WAIT_ROW) ||
                      (state_q == S_ACK_ROW) || (state_q == S_END_PASS));

  // Next-state, datapath updates and per-state pulse outputs.
  always_comb begin
    state_d             = state_q;
    shape0_d            = shape0_q;
    shape1_d            = shape1_q;
    steps_d             = steps_q;
    row_d               = row_q;
    step_d              = step_q;
    error_d             = error_q;
    res_valid_d         = 1'b0;
    res_row_d           = res_row_q;
    res_data_d          = res_data_q;
    wd_clear            = 1'b0;
    wd_enable           = 1'b0;
    pipe_start          = 1'b0;
    pipe_return_default = 1'b0;
    pipe_final_done     = 1'b0;
    done                = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          error_d = 1'b0;
          if ((shape_0 != '0) && (shape_1 != '0) && (num_steps != '0)) begin
            shape0_d = shape_0;
            shape1_d = shape_1;
            steps_d  = num_steps;
            row_d    = '0;
            step_d   = '0;
            state_d  = S_LAUNCH;
          end else begin
            state_d  = S_DONE;
          end
        end
      end
      S_LAUNCH: begin
        pipe_start = 1'b1;
        wd_clear   = 1'b1;
        state_d    = S_WAIT_ROW;
      end
      S_WAIT_ROW: begin
        wd_enable = 1'b1;
        if (pipe_data_ready) begin
          res_valid_d = 1'b1;
          res_row_d   = row_q;
          res_data_d  = pipe_out_acc;
          state_d     = S_ACK_ROW;
        end else if (wd_expired) begin
          state_d = S_ERROR;
        end
      end
      S_ACK_ROW: begin
        pipe_return_default = 1'b1;
        if (row_q == (shape0_q - MAX_DIM'(1))) begin
          state_d = S_END_PASS;
        end else begin
          row_d    = row_q + MAX_DIM'(1);
          wd_clear = 1'b1;
          state_d  = S_WAIT_ROW;
        end
      end
      S_END_PASS: begin
        pipe_final_done = 1'b1;
        if (step_q == (steps_q - STEP_W'(1))) begin
          state_d = S_DONE;
        end else begin
          step_d  = step_q + STEP_W'(1);
          row_d   = '0;
          state_d = S_LAUNCH;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        pipe_final_done = 1'b1;
        done            = 1'b1;
        error_d         = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Overflow outranks a same-cycle row result and freezes the counters.
    if (ovf_abort) begin
      state_d     = S_ERROR;
      res_valid_d = 1'b0;
      res_row_d   = res_row_q;
      res_data_d  = res_data_q;
      row_d       = row_q;
      step_d      = step_q;
    end
  end

  // State, configuration, counters and captured result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shape0_q    <= '0;
      shape1_q    <= '0;
      steps_q     <= '0;
      row_q       <= '0;
      step_q      <= '0;
      error_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_row_q   <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      shape0_q    <= shape0_d;
      shape1_q    <= shape1_d;
      steps_q     <= steps_d;
      row_q       <= row_d;
      step_q      <= step_d;
      error_q     <= error_d;
      res_valid_q <= res_valid_d;
      res_row_q   <= res_row_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign error        = error_q;
  assign result_valid = res_valid_q;
  assign result_row   = res_row_q;
  assign result_data  = res_data_q;
  assign step_count   = step_q;

endmodule

// File: tb/tb_euler_step_controller.sv
// Directed self-checking bench for euler_step_controller.
module tb_euler_step_controller;

  logic        clk;
  logic        rst;
  logic        go;
  logic [7:0]  num_steps;
  logic [5:0]  shape_0;
  logic [5:0]  shape_1;
  logic        pipe_data_ready;
  logic [15:0] pipe_out_acc;
  logic        pipe_overflow;
  logic        pipe_start;
  logic        pipe_return_default;
  logic        pipe_final_done;
  logic        busy;
  logic        done;
  logic        error;
  logic        result_valid;
  logic [5:0]  result_row;
  logic [15:0] result_data;
  logic [7:0]  step_count;

  euler_step_controller dut (
    .clk                 (clk),
    .rst                 (rst),
    .go                  (go),
    .num_steps           (num_steps),
    .shape_0             (shape_0),
    .shape_1             (shape_1),
    .pipe_data_ready     (pipe_data_ready),
    .pipe_out_acc        (pipe_out_acc),
    .pipe_overflow       (pipe_overflow),
    .pipe_start          (pipe_start),
    .pipe_return_default (pipe_return_default),
    .pipe_final_done     (pipe_final_done),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .result_valid        (result_valid),
    .result_row          (result_row),
    .result_data         (result_data),
    .step_count          (step_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Activity recorded by run_solve.
  int          n_start, n_valid, n_final, n_done, first_start, final_at;
  bit          done_seen;
  logic [31:0] rows[$];
  logic [31:0] steps_seen[$];
  logic [31:0] datas[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the pipeline from the LAUNCH cycle until done: answers each
  // start/acknowledge with ready after rdy_delay cycles (never if <= 0) and
  // optionally pulses go at cycle inject_at.
  task automatic run_solve(input int rdy_delay, input int inject_at);
    int  wait_ctr;
    bit  armed;
    int  n_rdy;
    n_start = 0; n_valid = 0; n_final = 0; n_done = 0;
    first_start = -1; final_at = -1; done_seen = 0;
    rows.delete(); steps_seen.delete(); datas.delete();
    wait_ctr = 0; armed = 0; n_rdy = 0;
    for (int c = 0; c < 400; c++) begin
      if (pipe_start) begin
        n_start++;
        if (first_start < 0) first_start = c;
        armed = 1; wait_ctr = 0;
      end
      if (pipe_return_default) begin
        armed = 1; wait_ctr = 0;
      end
      if (result_valid) begin
        n_valid++;
        rows.push_back(32'(result_row));
        steps_seen.push_back(32'(step_count));
        datas.push_back(32'(result_data));
      end
      if (pipe_final_done) begin
        n_final++;
        final_at = c;
      end
      if (done) begin
        n_done++;
        done_seen = 1;
      end
      go              = (c == inject_at);
      pipe_data_ready = (rdy_delay > 0) && armed && (wait_ctr == rdy_delay);
      pipe_out_acc    = 16'hA000 + 16'(n_rdy);
      if (pipe_data_ready) begin
        n_rdy++;
        armed = 0;
      end
      tick();
      if (armed) wait_ctr++;
      if (done_seen) break;
    end
    go = 1'b0;
    pipe_data_ready = 1'b0;
  endtask

  initial begin
    int exp_rows[6]  = '{0, 1, 2, 0, 1, 2};
    int exp_steps[6] = '{0, 0, 0, 1, 1, 1};

    rst = 1'b1; go = 1'b0; num_steps = '0; shape_0 = '0; shape_1 = '0;
    pipe_data_ready = 1'b0; pipe_out_acc = '0; pipe_overflow = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_pipe_start", 32'(pipe_start), 0);
    check("rst_result_valid", 32'(result_valid), 0);
    check("rst_step_count", 32'(step_count), 0);
    rst = 1'b0;
    tick();

    // Zero row count: straight to DONE, no launch, busy for one cycle
    shape_0 = 6'd0; shape_1 = 6'd3; num_steps = 8'd2; go = 1'b1;
    tick();
    go = 1'b0;
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 1);
    check("zero_no_start", 32'(pipe_start), 0);
    tick();
    check("zero_idle_busy", 32'(busy), 0);
    check("zero_idle_done", 32'(done), 0);

    // Zero step count behaves the same way
    shape_0 = 6'd3; num_steps = 8'd0; go = 1'b1;
    tick();
    go = 1'b0;
    check("zsteps_done", 32'(done), 1);
    check("zsteps_no_start", 32'(pipe_start), 0);
    tick();

    // Normal solve: 3x3 matrix, 2 steps, ready 5 cycles after start/ack
    shape_0 = 6'd3; shape_1 = 6'd3; num_steps = 8'd2; go = 1'b1;
    tick();
    check("norm_launch_start", 32'(pipe_start), 1);
    run_solve(5, -1);
    check("norm_done_seen", 32'(done_seen), 1);
    check("norm_n_start", 32'(n_start), 2);
    check("norm_n_valid", 32'(n_valid), 6);
    check("norm_n_final", 32'(n_final), 2);
    check("norm_n_done", 32'(n_done), 1);
    for (int i = 0; i < 6 && i < rows.size(); i++) begin
      check($sformatf("norm_row%0d", i), rows[i], 32'(exp_rows[i]));
      check($sformatf("norm_step%0d", i), steps_seen[i], 32'(exp_steps[i]));
      check($sformatf("norm_data%0d", i), datas[i], 32'h0000A000 + 32'(i));
    end
    check("norm_error", 32'(error), 0);
    check("norm_idle", 32'(busy), 0);

    // Watchdog: 1 row, 2 columns, no ready -> limit 4*2+16 = 24 WAIT_ROW cycles
    shape_0 = 6'd1; shape_1 = 6'd2; num_steps = 8'd1; go = 1'b1;
    tick();
    run_solve(0, -1);
    check("wd_done_seen", 32'(done_seen), 1);
    check("wd_latency", 32'(final_at - first_start), 25);
    check("wd_n_final", 32'(n_final), 1);
    check("wd_n_done", 32'(n_done), 1);
    check("wd_n_valid", 32'(n_valid), 0);
    check("wd_error", 32'(error), 1);

    // Overflow with same-cycle ready in WAIT_ROW: error wins, no result
    shape_0 = 6'd2; shape_1 = 6'd2; num_steps = 8'd1; go = 1'b1;
    tick();
    go = 1'b0;
    check("ovf_error_cleared", 32'(error), 0);
    tick();
    pipe_data_ready = 1'b1; pipe_overflow = 1'b1; pipe_out_acc = 16'h5555;
    tick();
    pipe_data_ready = 1'b0; pipe_overflow = 1'b0;
    check("ovf_final_done", 32'(pipe_final_done), 1);
    check("ovf_done", 32'(done), 1);
    check("ovf_no_valid", 32'(result_valid), 0);
    tick();
    check("ovf_error", 32'(error), 1);
    check("ovf_idle", 32'(busy), 0);
    check("ovf_no_valid_after", 32'(result_valid), 0);

    // Reset while waiting on row 1 of step 0
    shape_0 = 6'd3; shape_1 = 6'd3; num_steps = 8'd2; go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    pipe_data_ready = 1'b1; pipe_out_acc = 16'h1234;
    tick();
    pipe_data_ready = 1'b0;
    check("rstmid_row0_valid", 32'(result_valid), 1);
    tick();
    rst = 1'b1;
    tick();
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_final_done", 32'(pipe_final_done), 0);
    check("rstmid_done", 32'(done), 0);
    check("rstmid_valid", 32'(result_valid), 0);
    check("rstmid_data", 32'(result_data), 0);
    check("rstmid_error", 32'(error), 0);
    rst = 1'b0;
    tick();

    // go pulsed during WAIT_ROW with a different shape on the inputs is ignored
    shape_0 = 6'd3; shape_1 = 6'd3; num_steps = 8'd1; go = 1'b1;
    tick();
    go = 1'b0;
    shape_0 = 6'd5;
    run_solve(5, 3);
    check("ign_done_seen", 32'(done_seen), 1);
    check("ign_n_start", 32'(n_start), 1);
    check("ign_n_valid", 32'(n_valid), 3);
    check("ign_n_final", 32'(n_final), 1);
    check("ign_n_done", 32'(n_done), 1);
    for (int i = 0; i < 3 && i < rows.size(); i++) begin
      check($sformatf("ign_row%0d", i), rows[i], 32'(exp_rows[i]));
    end
    check("ign_error", 32'(error), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
